// File: rtl/parking_gate_arbiter.sv
// Arbiter for the shared entry/exit lane: opens one gate at a time, assigns the
// lowest free spot to each entering car and keeps saturating entry/exit totals.
module parking_gate_arbiter #(
  parameter int unsigned TIMEOUT = 20,  // max open cycles while the car stays on its loop
  parameter int unsigned GUARD   = 2    // closed cycles after a gate cycle before IDLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hour,
  input  logic       arrive_req,
  input  logic       depart_req,
  input  logic [2:0] spot,
  output logic       gate_in_open,
  output logic       gate_out_open,
  output logic [1:0] grant_spot,
  output logic       lot_full,
  output logic [7:0] entries,
  output logic [7:0] exits
);

  typedef enum logic [1:0] {StIdle, StInOpen, StOutOpen, StGuard} state_e;

  localparam logic       DirEntry    = 1'b0;
  localparam logic       DirExit     = 1'b1;
  localparam logic [1:0] NoSpot      = 2'd3;
  localparam logic [3:0] DayEnd      = 4'd8;
  // Timer holds the number of cycles already spent in the state, so the last
  // cycle is reached at value N-1.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
  localparam logic [7:0] GuardLast   = 8'(GUARD - 1);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       last_dir_q, last_dir_d;
  logic [1:0] grant_q, grant_d;
  logic [7:0] entries_q, entries_d;
  logic [7:0] exits_q, exits_d;
  logic [1:0] free_spot;
  logic       entry_ok;

  assign lot_full = &spot;
  assign entry_ok = arrive_req && !lot_full && (hour != DayEnd);

  // Lowest unoccupied spot; only consulted when the lot is not full.
  always_comb begin
    free_spot = NoSpot;
    if (!spot[0])      free_spot = 2'd0;
    else if (!spot[1]) free_spot = 2'd1;
    else if (!spot[2]) free_spot = 2'd2;
  end

  // Next-state logic: arbitration, open/guard timing and counter updates.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 8'd1;
    last_dir_d = last_dir_q;
    grant_d    = grant_q;
    entries_d  = entries_q;
    exits_d    = exits_q;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        // On a tie, the direction not served last time wins.
        if (entry_ok && (!depart_req || last_dir_q == DirExit)) begin
          state_d    = StInOpen;
          last_dir_d = DirEntry;
          grant_d    = free_spot;
        end else if (depart_req) begin
          state_d    = StOutOpen;
          last_dir_d = DirExit;
        end
      end
      StInOpen: begin
        if (!arrive_req) begin
          state_d = StGuard;
          timer_d = '0;
          if (entries_q != 8'hFF) entries_d = entries_q + 8'd1;
        end else if (timer_q == TimeoutLast) begin
          state_d = StGuard;
          timer_d = '0;
        end
      end
      StOutOpen: begin
        if (!depart_req) begin
          state_d = StGuard;
          timer_d = '0;
          if (exits_q != 8'hFF) exits_d = exits_q + 8'd1;
        end else if (timer_q == TimeoutLast) begin
          state_d = StGuard;
          timer_d = '0;
        end
      end
      StGuard: begin
        if (timer_q == GuardLast) begin
          state_d = StIdle;
          timer_d = '0;
          grant_d = NoSpot;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      last_dir_q <= DirExit;
      grant_q    <= NoSpot;
      entries_q  <= '0;
      exits_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      last_dir_q <= last_dir_d;
      grant_q    <= grant_d;
      entries_q  <= entries_d;
      exits_q    <= exits_d;
    end
  end

  assign gate_in_open  = (state_q == StInOpen);
  assign gate_out_open = (state_q == StOutOpen);
  assign grant_spot    = grant_q;
  assign entries       = entries_q;
  assign exits         = exits_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: per-cycle vector table plus
// hand-written timeout, saturation and mid-operation reset sequences.
module tb_parking_gate_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] hour = 4'd2;
  logic       arrive_req = 1'b0;
  logic       depart_req = 1'b0;
  logic [2:0] spot = 3'b000;
  logic       gate_in_open, gate_out_open, lot_full;
  logic [1:0] grant_spot;
  logic [7:0] entries, exits;

  int tests = 0;
  int fails = 0;

  parking_gate_arbiter #(.TIMEOUT(20), .GUARD(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .hour          (hour),
    .arrive_req    (arrive_req),
    .depart_req    (depart_req),
    .spot          (spot),
    .gate_in_open  (gate_in_open),
    .gate_out_open (gate_out_open),
    .grant_spot    (grant_spot),
    .lot_full      (lot_full),
    .entries       (entries),
    .exits         (exits)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (gate_in_open && gate_out_open) begin
      tests++;
      fails++;
      $display("FAIL both_gates_open: in=1 out=1, required never both");
    end
  end

  typedef struct {
    logic       rst;
    logic [3:0] hour;
    logic       arr;
    logic       dep;
    logic [2:0] spot;
    logic       e_in;
    logic       e_out;
    logic [1:0] e_grant;
    logic       e_full;
    logic [7:0] e_ent;
    logic [7:0] e_ext;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Apply inputs, clock one edge, sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic one_exit();
    depart_req = 1'b1;
    step();
    depart_req = 1'b0;
    repeat (3) step();
  endtask

  int run_hi;
  int run_lo;

  initial begin
    #1;
    // Fields: rst hour arr dep spot | in out grant full entries exits
    // Single entry with spot 0 occupied.
    vq.push_back('{1, 2, 0, 0, 3'b001, 0, 0, 3, 0, 0, 0});
    vq.push_back('{0, 2, 1, 0, 3'b001, 1, 0, 1, 0, 0, 0});
    vq.push_back('{0, 2, 1, 0, 3'b001, 1, 0, 1, 0, 0, 0});
    vq.push_back('{0, 2, 1, 0, 3'b001, 1, 0, 1, 0, 0, 0});
    vq.push_back('{0, 2, 1, 0, 3'b001, 1, 0, 1, 0, 0, 0});
    vq.push_back('{0, 2, 0, 0, 3'b001, 0, 0, 1, 0, 1, 0});
    vq.push_back('{0, 2, 0, 0, 3'b001, 0, 0, 1, 0, 1, 0});
    vq.push_back('{0, 2, 0, 0, 3'b001, 0, 0, 3, 0, 1, 0});
    // Tie arbitration: entry first, then exit, then entry; requests in guard held off.
    vq.push_back('{1, 2, 1, 1, 3'b000, 0, 0, 3, 0, 0, 0});
    vq.push_back('{0, 2, 1, 1, 3'b000, 1, 0, 0, 0, 0, 0});
    vq.push_back('{0, 2, 0, 1, 3'b000, 0, 0, 0, 0, 1, 0});
    vq.push_back('{0, 2, 1, 1, 3'b000, 0, 0, 0, 0, 1, 0});
    vq.push_back('{0, 2, 1, 1, 3'b000, 0, 0, 3, 0, 1, 0});
    vq.push_back('{0, 2, 1, 1, 3'b000, 0, 1, 3, 0, 1, 0});
    vq.push_back('{0, 2, 1, 0, 3'b000, 0, 0, 3, 0, 1, 1});
    vq.push_back('{0, 2, 1, 1, 3'b000, 0, 0, 3, 0, 1, 1});
    vq.push_back('{0, 2, 1, 1, 3'b000, 0, 0, 3, 0, 1, 1});
    vq.push_back('{0, 2, 1, 1, 3'b000, 1, 0, 0, 0, 1, 1});
    // Lot full blocks entry but not exit; day end blocks entry.
    vq.push_back('{1, 2, 1, 0, 3'b111, 0, 0, 3, 1, 0, 0});
    vq.push_back('{0, 2, 1, 0, 3'b111, 0, 0, 3, 1, 0, 0});
    vq.push_back('{0, 2, 1, 0, 3'b111, 0, 0, 3, 1, 0, 0});
    vq.push_back('{0, 2, 1, 1, 3'b111, 0, 1, 3, 1, 0, 0});
    vq.push_back('{0, 2, 1, 0, 3'b111, 0, 0, 3, 1, 0, 1});
    vq.push_back('{0, 8, 1, 0, 3'b000, 0, 0, 3, 0, 0, 1});
    vq.push_back('{0, 8, 1, 0, 3'b000, 0, 0, 3, 0, 0, 1});
    vq.push_back('{0, 8, 1, 0, 3'b000, 0, 0, 3, 0, 0, 1});
    vq.push_back('{0, 8, 1, 0, 3'b000, 0, 0, 3, 0, 0, 1});
    vq.push_back('{0, 2, 1, 0, 3'b000, 1, 0, 0, 0, 0, 1});

    foreach (vq[i]) begin
      rst        = vq[i].rst;
      hour       = vq[i].hour;
      arrive_req = vq[i].arr;
      depart_req = vq[i].dep;
      spot       = vq[i].spot;
      step();
      check($sformatf("vec%0d {in,out,grant,full,ent,ext}", i),
            {10'd0, gate_in_open, gate_out_open, grant_spot, lot_full, entries, exits},
            {10'd0, vq[i].e_in, vq[i].e_out, vq[i].e_grant, vq[i].e_full, vq[i].e_ent,
             vq[i].e_ext});
    end

    // Timeout: request held; gate open exactly 20 cycles, no entry counted,
    // spot changes while open leave grant_spot alone, re-grant after 3 closed cycles.
    arrive_req = 1'b0;
    depart_req = 1'b0;
    hour = 4'd2;
    spot = 3'b000;
    do_reset();
    arrive_req = 1'b1;
    step();
    check("timeout_first_open", {31'd0, gate_in_open}, 32'd1);
    run_hi = 0;
    for (int c = 0; c < 40 && gate_in_open; c++) begin
      run_hi++;
      if (run_hi == 5) spot = 3'b111;
      if (gate_in_open) check("timeout_grant_held", {30'd0, grant_spot}, 32'd0);
      step();
    end
    check("timeout_open_cycles", run_hi, 20);
    check("timeout_entries", {24'd0, entries}, 32'd0);
    spot = 3'b000;
    run_lo = 0;
    for (int c = 0; c < 10 && !gate_in_open; c++) begin
      run_lo++;
      step();
    end
    check("timeout_closed_cycles", run_lo, 3);
    check("timeout_regrant", {31'd0, gate_in_open}, 32'd1);

    // Saturation over 260 completed exits.
    arrive_req = 1'b0;
    do_reset();
    for (int n = 0; n < 255; n++) one_exit();
    check("exits_at_255", {24'd0, exits}, 32'd255);
    for (int n = 0; n < 5; n++) one_exit();
    check("exits_saturated", {24'd0, exits}, 32'd255);

    // Reset during OUT_OPEN with both requests pending.
    depart_req = 1'b1;
    step();
    check("rst_pre_out_open", {31'd0, gate_out_open}, 32'd1);
    arrive_req = 1'b1;
    rst = 1'b1;
    step();
    check("rst_gate_out", {31'd0, gate_out_open}, 32'd0);
    check("rst_exits", {24'd0, exits}, 32'd0);
    check("rst_grant", {30'd0, grant_spot}, 32'd3);
    rst = 1'b0;
    step();
    check("rst_tie_entry", {30'd0, gate_in_open, gate_out_open}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
